// File: rtl/hazard_scoreboard_pkg.sv
// Shared hazard-unit constants: forward select codes, Tnew/Tuse classes and the
// match-stage enum used to resolve the youngest producer of a source register.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_D_RF  = 2'b00;
  localparam logic [1:0] FWD_D_E   = 2'b01;
  localparam logic [1:0] FWD_D_M   = 2'b10;
  localparam logic [1:0] FWD_D_W   = 2'b11;

  localparam logic [1:0] FWD_E_REG = 2'b00;
  localparam logic [1:0] FWD_E_M   = 2'b01;
  localparam logic [1:0] FWD_E_W   = 2'b10;

  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;

  typedef enum logic [1:0] {
    STG_NONE,
    STG_E,
    STG_M,
    STG_W
  } match_stage_e;

  function automatic logic [1:0] fwd_d_code(input match_stage_e stg);
    case (stg)
      STG_E:   fwd_d_code = FWD_D_E;
      STG_M:   fwd_d_code = FWD_D_M;
      STG_W:   fwd_d_code = FWD_D_W;
      default: fwd_d_code = FWD_D_RF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_tag_stage.sv
// One pipeline tag register {valid, waddr, tnew}; the incoming tnew is optionally
// decremented (saturating at 0) as the tag moves one stage down the pipe.
module hazard_tag_stage
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int TNEW_W = 2,
  parameter bit DEC_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic              valid_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [TNEW_W-1:0] tnew_o
);

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [TNEW_W-1:0] tnew_q,  tnew_d;

  always_comb begin
    valid_d = valid_i;
    waddr_d = waddr_i;
    tnew_d  = tnew_i;
    if (DEC_EN && (tnew_i != '0)) tnew_d = tnew_i - TNEW_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      waddr_q <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      tnew_q  <= tnew_d;
    end
  end

  assign valid_o = valid_q;
  assign waddr_o = waddr_q;
  assign tnew_o  = tnew_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard unit for the 5-stage pipeline: stalls, D/E forward selects and
// an optional mult/div busy window enabled by defining HAZARD_MD_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int MDC_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [TNEW_W-1:0] d_tuse_rs,
  input  logic [TNEW_W-1:0] d_tuse_rt,
  input  logic              d_wr_en,
  input  logic [REG_AW-1:0] d_waddr,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall_d,
  output logic              flush_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              md_busy
);

  logic              accept;
  logic              gpr_stall;
  logic              md_stall;

  logic              e_valid, m_valid, w_valid;
  logic [REG_AW-1:0] e_waddr, m_waddr, w_waddr;
  logic [TNEW_W-1:0] e_tnew,  m_tnew,  w_tnew;

  logic [REG_AW-1:0] e_rs_q, e_rs_d, e_rt_q, e_rt_d;
  logic              e_use_rs_q, e_use_rs_d, e_use_rt_q, e_use_rt_d;

  match_stage_e      stg_rs, stg_rt;
  logic [TNEW_W-1:0] tnew_rs, tnew_rt;

  assign accept = d_valid & ~stall_d;

  hazard_tag_stage #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .DEC_EN(1'b0)) u_tag_e (
    .clk(clk), .reset(reset),
    .valid_i(accept & d_wr_en), .waddr_i(d_waddr), .tnew_i(d_tnew),
    .valid_o(e_valid), .waddr_o(e_waddr), .tnew_o(e_tnew)
  );

  hazard_tag_stage #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .DEC_EN(1'b1)) u_tag_m (
    .clk(clk), .reset(reset),
    .valid_i(e_valid), .waddr_i(e_waddr), .tnew_i(e_tnew),
    .valid_o(m_valid), .waddr_o(m_waddr), .tnew_o(m_tnew)
  );

  hazard_tag_stage #(.REG_AW(REG_AW), .TNEW_W(TNEW_W), .DEC_EN(1'b1)) u_tag_w (
    .clk(clk), .reset(reset),
    .valid_i(m_valid), .waddr_i(m_waddr), .tnew_i(m_tnew),
    .valid_o(w_valid), .waddr_o(w_waddr), .tnew_o(w_tnew)
  );

  // E source tags drop their use bits on a bubble so a stalled slot never forwards.
  always_comb begin
    e_rs_d     = accept ? d_rs : e_rs_q;
    e_rt_d     = accept ? d_rt : e_rt_q;
    e_use_rs_d = accept & d_use_rs;
    e_use_rt_d = accept & d_use_rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rs_q     <= '0;
      e_rt_q     <= '0;
      e_use_rs_q <= 1'b0;
      e_use_rt_q <= 1'b0;
    end else begin
      e_rs_q     <= e_rs_d;
      e_rt_q     <= e_rt_d;
      e_use_rs_q <= e_use_rs_d;
      e_use_rt_q <= e_use_rt_d;
    end
  end

  function automatic match_stage_e youngest_match(input logic [REG_AW-1:0] s);
    youngest_match = STG_NONE;
    if (s != '0) begin
      if (e_valid && (e_waddr == s))      youngest_match = STG_E;
      else if (m_valid && (m_waddr == s)) youngest_match = STG_M;
      else if (w_valid && (w_waddr == s)) youngest_match = STG_W;
    end
  endfunction

  function automatic logic [TNEW_W-1:0] stage_tnew(input match_stage_e stg);
    case (stg)
      STG_E:   stage_tnew = e_tnew;
      STG_M:   stage_tnew = m_tnew;
      STG_W:   stage_tnew = w_tnew;
      default: stage_tnew = '0;
    endcase
  endfunction

  function automatic logic [1:0] e_fwd(input logic use_s, input logic [REG_AW-1:0] s);
    e_fwd = FWD_E_REG;
    if (use_s && (s != '0)) begin
      if (m_valid && (m_waddr == s) && (m_tnew == '0)) e_fwd = FWD_E_M;
      else if (w_valid && (w_waddr == s))              e_fwd = FWD_E_W;
    end
  endfunction

  // A nonzero-tnew match that does not stall leaves D on the RF path; E corrects it.
  always_comb begin
    stg_rs    = youngest_match(d_rs);
    stg_rt    = youngest_match(d_rt);
    tnew_rs   = stage_tnew(stg_rs);
    tnew_rt   = stage_tnew(stg_rt);
    gpr_stall = d_valid &
                ((d_use_rs & (stg_rs != STG_NONE) & (tnew_rs > d_tuse_rs)) |
                 (d_use_rt & (stg_rt != STG_NONE) & (tnew_rt > d_tuse_rt)));
    fwd_rs_d  = ((stg_rs != STG_NONE) && (tnew_rs == '0)) ? fwd_d_code(stg_rs) : FWD_D_RF;
    fwd_rt_d  = ((stg_rt != STG_NONE) && (tnew_rt == '0)) ? fwd_d_code(stg_rt) : FWD_D_RF;
    fwd_rs_e  = e_fwd(e_use_rs_q, e_rs_q);
    fwd_rt_e  = e_fwd(e_use_rt_q, e_rt_q);
  end

`ifdef HAZARD_MD_EN
  logic [MDC_W-1:0] md_cnt_q, md_cnt_d;

  // The stall still holds at count 1, so the waiting HI/LO user issues once it reads 0.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (accept && d_md_start)  md_cnt_d = d_md_div ? MDC_W'(DIV_LAT) : MDC_W'(MULT_LAT);
    else if (md_cnt_q != '0)   md_cnt_d = md_cnt_q - MDC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) md_cnt_q <= '0;
    else       md_cnt_q <= md_cnt_d;
  end

  assign md_busy  = (md_cnt_q != '0);
  assign md_stall = d_valid & (d_md_use | d_md_start) & md_busy;
`else
  logic md_unused;
  assign md_unused = ^{d_md_start, d_md_div, d_md_use, MDC_W'(MULT_LAT), MDC_W'(DIV_LAT)};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

  assign stall_d = gpr_stall | md_stall;
  assign flush_e = stall_d;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations are queued as each D-stage
// instruction is driven and popped when the outputs are sampled after settling.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

`ifdef HAZARD_MD_EN
  localparam logic MD_ON = 1'b1;
`else
  localparam logic MD_ON = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [1:0] trs, trt;
    logic       wr;
    logic [4:0] wa;
    logic [1:0] tn;
    logic       ms, md, mu;
  } din_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] frsd, frtd, frse, frte;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid, d_use_rs, d_use_rt, d_wr_en, d_md_start, d_md_div, d_md_use;
  logic [4:0] d_rs, d_rt, d_waddr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall_d, flush_e, md_busy;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  exp_t  expq[$];
  string tagq[$];
  int    compared   = 0;
  int    mismatched = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_en(d_wr_en), .d_waddr(d_waddr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall_d(stall_d), .flush_e(flush_e), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic din_t bub();
    din_t d;
    d = '0;
    return d;
  endfunction

  function automatic din_t prod(input logic [4:0] wa, input logic [1:0] tn);
    din_t d;
    d = '0; d.v = 1'b1; d.wr = 1'b1; d.wa = wa; d.tn = tn;
    return d;
  endfunction

  function automatic din_t cons(input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                                input logic [4:0] rt, input logic urt, input logic [1:0] trt);
    din_t d;
    d = '0; d.v = 1'b1;
    d.rs = rs; d.urs = urs; d.trs = trs;
    d.rt = rt; d.urt = urt; d.trt = trt;
    return d;
  endfunction

  function automatic din_t mdop(input logic start, input logic div, input logic use_hilo);
    din_t d;
    d = '0; d.v = 1'b1; d.ms = start; d.md = div; d.mu = use_hilo;
    return d;
  endfunction

  function automatic exp_t ex(input logic stall, input logic [1:0] frsd, input logic [1:0] frtd,
                              input logic [1:0] frse, input logic [1:0] frte, input logic busy);
    exp_t e;
    e.stall = stall; e.frsd = frsd; e.frtd = frtd; e.frse = frse; e.frte = frte; e.busy = busy;
    return e;
  endfunction

  task automatic drive(input din_t d);
    d_valid = d.v; d_rs = d.rs; d_rt = d.rt; d_use_rs = d.urs; d_use_rt = d.urt;
    d_tuse_rs = d.trs; d_tuse_rt = d.trt; d_wr_en = d.wr; d_waddr = d.wa; d_tnew = d.tn;
    d_md_start = d.ms; d_md_div = d.md; d_md_use = d.mu;
  endtask

  task automatic cmp(input string tag, input string name, input logic [1:0] obs, input logic [1:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, req);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    if (expq.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e   = expq.pop_front();
      tag = tagq.pop_front();
      cmp(tag, "stall_d",  {1'b0, stall_d}, {1'b0, e.stall});
      cmp(tag, "flush_e",  {1'b0, flush_e}, {1'b0, e.stall});
      cmp(tag, "fwd_rs_d", fwd_rs_d, e.frsd);
      cmp(tag, "fwd_rt_d", fwd_rt_d, e.frtd);
      cmp(tag, "fwd_rs_e", fwd_rs_e, e.frse);
      cmp(tag, "fwd_rt_e", fwd_rt_e, e.frte);
      cmp(tag, "md_busy",  {1'b0, md_busy}, {1'b0, e.busy});
    end
  endtask

  task automatic applyStimulus(input string tag, input din_t d, input exp_t e);
    @(negedge clk);
    reset = 1'b0;
    drive(d);
    expq.push_back(e);
    tagq.push_back(tag);
    #1;
    checkOutput();
  endtask

  task automatic resetPulse(input din_t d);
    @(negedge clk);
    reset = 1'b1;
    drive(d);
  endtask

  initial begin
    reset = 1'b1;
    drive(bub());
    @(posedge clk);
    @(posedge clk);

    applyStimulus("reset_state", bub(), ex(0, FWD_D_RF, FWD_D_RF, FWD_E_REG, FWD_E_REG, 0));

    // addu r8 then beq r8: one stall, then forward from M, then E takes it from W
    applyStimulus("addu_beq_0", prod(5'd8, TNEW_ALU), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("addu_beq_1", cons(5'd8, 1, TUSE_D, 5'd0, 0, TUSE_D), ex(1, 0, 0, 0, 0, 0));
    applyStimulus("addu_beq_2", cons(5'd8, 1, TUSE_D, 5'd0, 0, TUSE_D), ex(0, FWD_D_M, 0, 0, 0, 0));
    applyStimulus("addu_beq_3", bub(), ex(0, 0, 0, FWD_E_W, 0, 0));

    // lw r9 then addu r9,r9 (tuse=E)
    resetPulse(bub());
    applyStimulus("lw_addu_0", prod(5'd9, TNEW_LOAD), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("lw_addu_1", cons(5'd9, 1, TUSE_E, 5'd9, 1, TUSE_E), ex(1, 0, 0, 0, 0, 0));
    applyStimulus("lw_addu_2", cons(5'd9, 1, TUSE_E, 5'd9, 1, TUSE_E), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("lw_addu_3", bub(), ex(0, 0, 0, FWD_E_W, FWD_E_W, 0));

    // jal r31 then jr r31: forward from E without stalling
    resetPulse(bub());
    applyStimulus("jal_jr_0", prod(5'd31, TNEW_PC8), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("jal_jr_1", cons(5'd31, 1, TUSE_D, 5'd0, 0, TUSE_D), ex(0, FWD_D_E, 0, 0, 0, 0));
    applyStimulus("jal_jr_2", bub(), ex(0, 0, 0, FWD_E_M, 0, 0));
    applyStimulus("jal_jr_3", bub(), ex(0, 0, 0, 0, 0, 0));

    // rt-only consumer of an ALU result needed in D
    resetPulse(bub());
    applyStimulus("rt_dep_0", prod(5'd10, TNEW_ALU), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("rt_dep_1", cons(5'd0, 0, TUSE_D, 5'd10, 1, TUSE_D), ex(1, 0, 0, 0, 0, 0));
    applyStimulus("rt_dep_2", cons(5'd0, 0, TUSE_D, 5'd10, 1, TUSE_D), ex(0, 0, FWD_D_M, 0, 0, 0));
    applyStimulus("rt_dep_3", bub(), ex(0, 0, 0, 0, FWD_E_W, 0));

    // Younger E writer of r5 masks an older ready M writer
    resetPulse(bub());
    applyStimulus("mask_0", prod(5'd5, TNEW_PC8), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("mask_1", prod(5'd5, TNEW_ALU), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("mask_2", cons(5'd5, 1, TUSE_E, 5'd0, 0, TUSE_E), ex(0, FWD_D_RF, 0, 0, 0, 0));
    applyStimulus("mask_3", bub(), ex(0, 0, 0, FWD_E_M, 0, 0));

    // r0 is never a hazard
    resetPulse(bub());
    applyStimulus("r0_0", prod(5'd0, TNEW_LOAD), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("r0_1", cons(5'd0, 1, TUSE_D, 5'd0, 1, TUSE_D), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("r0_2", bub(), ex(0, 0, 0, 0, 0, 0));

    // mult then mfhi
    resetPulse(bub());
    applyStimulus("mult_0", mdop(1, 0, 0), ex(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      applyStimulus("mult_busy", mdop(0, 0, 1), ex(MD_ON, 0, 0, 0, 0, MD_ON));
    applyStimulus("mult_issue", mdop(0, 0, 1), ex(0, 0, 0, 0, 0, 0));

    // div then mfhi
    resetPulse(bub());
    applyStimulus("div_0", mdop(1, 1, 0), ex(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++)
      applyStimulus("div_busy", mdop(0, 0, 1), ex(MD_ON, 0, 0, 0, 0, MD_ON));
    applyStimulus("div_issue", mdop(0, 0, 1), ex(0, 0, 0, 0, 0, 0));

    // Reset during a load-use stall
    resetPulse(bub());
    applyStimulus("rst_lw_0", prod(5'd9, TNEW_LOAD), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("rst_lw_1", cons(5'd9, 1, TUSE_E, 5'd0, 0, TUSE_E), ex(1, 0, 0, 0, 0, 0));
    resetPulse(cons(5'd9, 1, TUSE_E, 5'd0, 0, TUSE_E));
    applyStimulus("rst_lw_2", cons(5'd9, 1, TUSE_E, 5'd0, 0, TUSE_E), ex(0, 0, 0, 0, 0, 0));

    // Reset during MD busy
    resetPulse(bub());
    applyStimulus("rst_md_0", mdop(1, 1, 0), ex(0, 0, 0, 0, 0, 0));
    applyStimulus("rst_md_1", mdop(0, 0, 1), ex(MD_ON, 0, 0, 0, 0, MD_ON));
    resetPulse(mdop(0, 0, 1));
    applyStimulus("rst_md_2", mdop(0, 0, 1), ex(0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
